// File: rtl/sop_coef_loader_if.sv
// Coefficient-load bus between the config source and sop_coef_loader.
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high; load_ready depends only on registered state,
// so the source may hold load_valid/load_data until it sees load_ready.
interface sop_coef_loader_if #(
    parameter int width = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [width:0]   load_data;
    logic             load_first;
    logic             abort;
    logic             sample_en;
    logic [width:0]   c0;
    logic [width:0]   c1;
    logic [width:0]   c2;
    logic [width:0]   c3;
    logic             coef_valid;
    logic             coef_update;
    logic             pending;
    logic [1:0]       dbg_state;

    modport master (
        output load_valid, load_data, load_first, abort, sample_en,
        input  load_ready, c0, c1, c2, c3, coef_valid, coef_update, pending, dbg_state
    );

    modport slave (
        input  load_valid, load_data, load_first, abort, sample_en,
        output load_ready, c0, c1, c2, c3, coef_valid, coef_update, pending, dbg_state
    );
endinterface

// File: rtl/sop_coef_loader.sv
// Collects four coefficient words into shadow registers and commits the
// whole set to the filter's c0..c3 on a sample boundary, so the filter
// never sees a partially updated set.
module sop_coef_loader #(
    parameter int width = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    sop_coef_loader_if.slave    bus
);
    localparam int cw = width + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      idx;
    logic [1:0]      idx_next;
    logic [1:0]      wr_idx;
    logic            shadow_we;
    logic            commit;
    logic [cw-1:0]   shadow [4];
    logic [cw-1:0]   coef [4];
    logic            coef_valid;
    logic            coef_update;

    // State and write index register; IDLE lasts exactly one cycle after reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next state, shadow write strobe and commit decision; abort beats everything.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        shadow_we  = 1'b0;
        commit     = 1'b0;
        wr_idx     = bus.load_first ? 2'd0 : idx;
        case (state)
            IDLE: begin
                state_next = LOAD;
                idx_next   = 2'd0;
            end
            LOAD: begin
                if (bus.abort) begin
                    idx_next = 2'd0;
                end else if (bus.load_valid) begin
                    shadow_we = 1'b1;
                    if (wr_idx == 2'd3) begin
                        state_next = PEND;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = wr_idx + 2'd1;
                    end
                end
            end
            PEND: begin
                if (bus.abort) begin
                    state_next = LOAD;
                    idx_next   = 2'd0;
                end else if (bus.sample_en) begin
                    commit     = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 2'd0;
            end
        endcase
    end

    // Shadow capture of accepted words.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else if (shadow_we) begin
            shadow[wr_idx] <= bus.load_data;
        end
    end

    // Atomic commit of the shadow set to the active coefficients.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) coef[i] <= '0;
            coef_valid  <= 1'b0;
            coef_update <= 1'b0;
        end else begin
            coef_update <= commit;
            if (commit) begin
                for (int i = 0; i < 4; i++) coef[i] <= shadow[i];
                coef_valid <= 1'b1;
            end
        end
    end

    assign bus.load_ready  = (state == LOAD);
    assign bus.pending     = (state == PEND);
    assign bus.c0          = coef[0];
    assign bus.c1          = coef[1];
    assign bus.c2          = coef[2];
    assign bus.c3          = coef[3];
    assign bus.coef_valid  = coef_valid;
    assign bus.coef_update = coef_update;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_sop_coef_loader.sv
// Directed bench for sop_coef_loader: bring-up, basic load, sample_en
// collision, load_first resync, abort, and asynchronous reset in PEND.
module tb_sop_coef_loader;
    localparam int width = 4;
    localparam int cw = width + 1;

    logic CLK;
    logic RESET;
    int   errors;
    int   checks;

    logic [cw-1:0] exp_q [$];
    logic [cw-1:0] exp_c [4];

    sop_coef_loader_if #(.width(width)) bus ();

    sop_coef_loader #(.width(width)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver: present one word at a negedge once load_ready is seen, hold it
    // across the accepting edge, then drop valid.
    task automatic send_beat(input logic [cw-1:0] data, input logic first);
        int n;
        n = 0;
        while (bus.load_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) check("beat_ready_timeout", 0, 1);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_first = first;
        @(negedge CLK);
        bus.load_valid = 1'b0;
        bus.load_first = 1'b0;
    endtask

    task automatic send_set(input logic [cw-1:0] a, input logic [cw-1:0] b,
                            input logic [cw-1:0] c, input logic [cw-1:0] d);
        send_beat(a, 1'b1);
        send_beat(b, 1'b0);
        send_beat(c, 1'b0);
        send_beat(d, 1'b0);
    endtask

    task automatic expect_set(input logic [cw-1:0] a, input logic [cw-1:0] b,
                              input logic [cw-1:0] c, input logic [cw-1:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    // Scoreboard: a commit moves the oldest queued set into the active model.
    task automatic take_commit();
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() > 0) exp_c[i] = exp_q.pop_front();
            else check("exp_q_empty", 0, 1);
        end
    endtask

    task automatic check_active(input string tag);
        check({tag, "_c0"}, 32'(bus.c0), 32'(exp_c[0]));
        check({tag, "_c1"}, 32'(bus.c1), 32'(exp_c[1]));
        check({tag, "_c2"}, 32'(bus.c2), 32'(exp_c[2]));
        check({tag, "_c3"}, 32'(bus.c3), 32'(exp_c[3]));
    endtask

    // One-cycle sample_en pulse in PEND; checks the cycle after the commit edge.
    task automatic commit_pulse(input string tag);
        bus.sample_en = 1'b1;
        @(negedge CLK);
        bus.sample_en = 1'b0;
        take_commit();
        check({tag, "_update"}, 32'(bus.coef_update), 1);
        check({tag, "_valid"}, 32'(bus.coef_valid), 1);
        check({tag, "_ready"}, 32'(bus.load_ready), 1);
        check({tag, "_pending"}, 32'(bus.pending), 0);
        check_active(tag);
        @(negedge CLK);
        check({tag, "_update_drop"}, 32'(bus.coef_update), 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 4; i++) exp_c[i] = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_first = 1'b0;
        bus.abort      = 1'b0;
        bus.sample_en  = 1'b0;
        RESET = 1'b1;

        // Bring-up
        repeat (3) @(negedge CLK);
        check("rst_c0", 32'(bus.c0), 0);
        check("rst_c3", 32'(bus.c3), 0);
        check("rst_valid", 32'(bus.coef_valid), 0);
        check("rst_update", 32'(bus.coef_update), 0);
        check("rst_pending", 32'(bus.pending), 0);
        RESET = 1'b0;
        #1;
        check("idle_ready", 32'(bus.load_ready), 0);
        @(negedge CLK);
        check("first_ready", 32'(bus.load_ready), 1);

        // Basic load, commit three cycles later
        expect_set(5'd3, 5'd5, 5'd7, 5'd9);
        send_set(5'd3, 5'd5, 5'd7, 5'd9);
        check("basic_pending", 32'(bus.pending), 1);
        check("basic_ready_low", 32'(bus.load_ready), 0);
        repeat (2) @(negedge CLK);
        check("basic_pending_hold", 32'(bus.pending), 1);
        check("basic_no_early", 32'(bus.coef_valid), 0);
        commit_pulse("basic");

        // Abort together with sample_en in PEND: no commit
        send_set(5'd1, 5'd2, 5'd3, 5'd4);
        check("abort_pending", 32'(bus.pending), 1);
        bus.abort     = 1'b1;
        bus.sample_en = 1'b1;
        @(negedge CLK);
        bus.abort     = 1'b0;
        bus.sample_en = 1'b0;
        check("abort_no_update", 32'(bus.coef_update), 0);
        check("abort_ready", 32'(bus.load_ready), 1);
        check("abort_pending_clr", 32'(bus.pending), 0);
        check_active("abort");

        // Abort mid-load clears the index: next words fill from c0 without load_first
        send_beat(5'd20, 1'b1);
        send_beat(5'd21, 1'b0);
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.abort = 1'b0;
        expect_set(5'd6, 5'd7, 5'd8, 5'd10);
        send_beat(5'd6, 1'b0);
        send_beat(5'd7, 1'b0);
        send_beat(5'd8, 1'b0);
        send_beat(5'd10, 1'b0);
        commit_pulse("midabort");

        // Collision: sample_en high throughout the load
        bus.sample_en = 1'b1;
        expect_set(5'd31, 5'd0, 5'd16, 5'd1);
        send_set(5'd31, 5'd0, 5'd16, 5'd1);
        check("coll_no_update", 32'(bus.coef_update), 0);
        check("coll_pending", 32'(bus.pending), 1);
        check_active("coll_old");
        @(negedge CLK);
        bus.sample_en = 1'b0;
        take_commit();
        check("coll_update", 32'(bus.coef_update), 1);
        check_active("coll");

        // Resync: a load_first beat discards the partial set
        @(negedge CLK);
        expect_set(5'd11, 5'd12, 5'd13, 5'd14);
        send_beat(5'd3, 1'b1);
        send_beat(5'd5, 1'b0);
        send_beat(5'd11, 1'b1);
        send_beat(5'd12, 1'b0);
        send_beat(5'd13, 1'b0);
        check("resync_not_yet", 32'(bus.pending), 0);
        send_beat(5'd14, 1'b0);
        check("resync_pending", 32'(bus.pending), 1);
        commit_pulse("resync");

        // Asynchronous reset while in PEND
        send_set(5'd1, 5'd2, 5'd3, 5'd4);
        check("rmid_pending", 32'(bus.pending), 1);
        #2;
        RESET = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) exp_c[i] = '0;
        check_active("rmid");
        check("rmid_valid", 32'(bus.coef_valid), 0);
        check("rmid_pending_clr", 32'(bus.pending), 0);
        check("rmid_ready", 32'(bus.load_ready), 0);
        @(negedge CLK);
        RESET = 1'b0;
        expect_set(5'd2, 5'd4, 5'd6, 5'd8);
        send_set(5'd2, 5'd4, 5'd6, 5'd8);
        commit_pulse("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sop_coef_loader.md
# sop_coef_loader

Coefficient programming front end for the four-tap sum-of-products filter. It accepts coefficient words one at a time over a valid/ready handshake and collects a full set of four (c0..c3) in shadow registers. It then commits the set atomically to the filter's coefficient inputs on the next sample boundary. The filter therefore never sees a partially updated coefficient set. It sits between the control/config source and the filter's c0..c3 ports in the same clock domain.

## Interface
- width, 4, filter data width; coefficients are width+1 bits (matches filter c0..c3)
- CLK  input  1  clock, rising edge
- RESET  input  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
- load_valid  input  1  source presents a coefficient word
- load_ready  output  1  block can accept a word this cycle
- load_data  input  width+1  coefficient word, two's complement not implied (unsigned, as the filter treats it)
- load_first  input  1  qualifies load_data as c0 of a new set (resynchronise)
- abort  input  1  discard partial/pending set
- sample_en  input  1  filter sample boundary strobe; commits only happen here
- c0, c1, c2, c3  output  width+1 each  active coefficients to filter
- coef_valid  output  1  at least one set committed since reset
- coef_update  output  1  one-cycle pulse, high in the cycle after a commit edge
- pending  output  1  full set held, waiting for sample_en

## Operation
- Beat accepted on rising CLK edge where load_valid && load_ready.
- States: IDLE, LOAD, PEND. Encoding is free; state register resets to IDLE.
- IDLE: load_ready=0. Unconditional transition to LOAD next edge; idx cleared to 0.
- LOAD: load_ready=1. On accepted beat, shadow[idx] <= load_data, idx <= idx+1.
  - If load_first=1 on an accepted beat, the word is written to shadow[0] and idx <= 1, regardless of the current idx. Earlier partial words are discarded.
  - Beat written with index 3 (after the load_first override, if any) → PEND, idx <= 0.
  - load_first on a non-accepted cycle is ignored.
- PEND: load_ready=0, pending=1. On edge with sample_en=1, c0..c3 <= shadow[0..3] simultaneously, coef_valid <= 1, coef_update <= 1, → LOAD.
- abort=1 (LOAD or PEND): idx <= 0, → LOAD, shadow contents are don't-care, active c0..c3 unchanged, no commit. abort has priority over an accepted beat and over sample_en in the same cycle.
- sample_en in LOAD or IDLE: no effect.
- Active c0..c3 hold their value indefinitely between commits.

## Timing
- Reset values: state IDLE, load_ready 0, pending 0, c0..c3 all 0, coef_valid 0, coef_update 0, idx 0, shadow 0.
- Reset asserted mid-load or in PEND: all of the above immediately (asynchronously). The pending set is lost.
- load_ready and pending are decoded from registered state only. They have no combinational path from load_valid, sample_en or abort.
- First load_ready=1 in the second cycle after RESET deasserts (IDLE lasts one cycle).
- Fourth beat accepted at edge N: pending=1 and load_ready=0 from cycle N+1. A sample_en in the same cycle as the 4th beat does NOT commit; the earliest commit edge is N+1.
- Commit at edge M: c0..c3 and coef_valid are new from cycle M+1. coef_update=1 for exactly cycle M+1. load_ready=1 from cycle M+1.
- Minimum set-to-set period: 4 beats + 1 commit edge = 5 cycles with continuous valid and sample_en.
- All outputs are registered.

## Test plan
- Reset/bring-up (width=4): hold RESET 3 cycles, release → c0..c3=0, coef_valid=0, load_ready=0 for one cycle, then 1.
- Basic load: beats 3,5,7,9 (first beat with load_first=1), sample_en pulsed 3 cycles later → pending=1 until the commit edge, then c0=3, c1=5, c2=7, c3=9, coef_valid=1, coef_update high exactly one cycle.
- Collision: sample_en held high continuously while loading 31,0,16,1 → no commit on the cycle the 4th beat is accepted. Commit occurs one edge later with c0..c3=31,0,16,1.
- Resync: load 3,5 then beat 11 with load_first=1, then 12,13,14, commit → c0..c3=11,12,13,14.
- Abort: after the basic load is committed, load 1,2,3,4 to PEND, assert abort together with sample_en → no coef_update, c0..c3 remain 3,5,7,9, load_ready=1 next cycle.
- Reset mid-operation: RESET asserted asynchronously between clock edges while in PEND → outputs 0 before the next CLK edge. After release, a fresh 4-beat load commits normally.
